alarm_annunciator: RTL

- Consumer end of the clock controller's alarm-match and hourly-chime outputs.
- Turns those outputs into a patterned buzzer drive and an alarm LED, with snooze, stop and auto-timeout handled by a ringing state machine.
- Runs entirely in the 10 Hz domain and sits between the clock controller and the board buzzer/LED pins.
- Also merges chime pulses onto the buzzer when no alarm is ringing.

---
 rtl/annunciator_pkg.sv | 35 +++
 rtl/key_edge_sync.sv | 31 +++
 rtl/alarm_annunciator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/annunciator_pkg.sv
// Shared definitions for the alarm annunciator: ringing state encodings,
// default timing constants and the buzzer beep pattern.
package annunciator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RING      = 2'd1,
        ST_SNOOZE    = 2'd2,
        ST_DISMISSED = 2'd3
    } ring_state_t;

    // Default timing at a 10 Hz tick: 60 s ring, 5 min snooze, 3 snoozes.
    localparam int unsigned RING_TICKS_DEF   = 600;
    localparam int unsigned SNOOZE_TICKS_DEF = 3000;
    localparam int unsigned SNOOZE_MAX_DEF   = 3;
    localparam int unsigned CNT_W_DEF        = 12;

    // Beep pattern: one-second frame of 10 phases, double beep on 0,1,4,5.
    localparam int unsigned PH_W       = 4;
    localparam int unsigned PH_LEN     = 10;
    localparam logic [PH_W-1:0] PH_LAST  = 4'(PH_LEN - 1);
    localparam logic [PH_W-1:0] PH_BLINK = 4'd5;
    localparam logic [15:0]     PH_ON_MASK = 16'h0033;

    // True when the buzzer should sound for the given pattern phase.
    function automatic logic beep_on(input logic [PH_W-1:0] ph);
        return PH_ON_MASK[ph];
    endfunction

    // True for the lit half of the 1 Hz LED blink.
    function automatic logic blink_on(input logic [PH_W-1:0] ph);
        return (ph < PH_BLINK);
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Key front end: two-flop synchronizer for an asynchronous active-low key,
// followed by a falling-edge detector. A held key yields a single press.
module key_edge_sync
(
    input  logic clk_10Hz,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the key and keep its previous synchronized value; idle-high.
    always_ff @(posedge clk_10Hz or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Press is the high-to-low transition of the synchronized key.
    assign press = prev & ~sync2;

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: turns the clock controller's alarm-match and hourly
// chime into a patterned buzzer drive and an alarm LED, with snooze, stop
// and auto-timeout handled by the ringing state machine.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for an alarm-match rise; buzzer carries the chime
//   RING      | double-beep pattern, LED blinks; times out to DISMISSED
//   SNOOZE    | silent, LED steady; returns to RING when the timer expires
//   DISMISSED | event finished; waits for alarm_match low so the same
//             | minute cannot re-trigger
module alarm_annunciator
    import annunciator_pkg::*;
#(
    parameter int unsigned RING_TICKS   = RING_TICKS_DEF,
    parameter int unsigned SNOOZE_TICKS = SNOOZE_TICKS_DEF,
    parameter int unsigned SNOOZE_MAX   = SNOOZE_MAX_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
)
(
    input  logic       clk_10Hz,
    input  logic       rst,
    input  logic       alarm_en,
    input  logic       alarm_match,
    input  logic       chime_in,
    input  logic       key_snooze_n,
    input  logic       key_stop_n,
    output logic       buzzer,
    output logic       alarm_led,
    output logic [1:0] ring_state,
    output logic [1:0] snooze_cnt
);

    // CNT_W must be wide enough for the larger of the two tick limits.
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TICKS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
    localparam logic [1:0]       SNZ_MAX     = 2'(SNOOZE_MAX);

    ring_state_t       state_q, state_n;
    logic [CNT_W-1:0]  tick_q, tick_n;
    logic [PH_W-1:0]   phase_q, phase_n;
    logic [1:0]        snz_q, snz_n;
    logic              buzzer_q, buzzer_n;
    logic              led_q, led_n;
    logic              match_d;
    logic              rise;
    logic              snooze_press;
    logic              stop_press;

    key_edge_sync u_snooze_key (
        .clk_10Hz (clk_10Hz),
        .rst      (rst),
        .key_n    (key_snooze_n),
        .press    (snooze_press)
    );

    key_edge_sync u_stop_key (
        .clk_10Hz (clk_10Hz),
        .rst      (rst),
        .key_n    (key_stop_n),
        .press    (stop_press)
    );

    // Delayed alarm_match for rising-edge detection; already in this domain.
    always_ff @(posedge clk_10Hz or negedge rst) begin
        if (!rst) begin
            match_d <= 1'b0;
        end else begin
            match_d <= alarm_match;
        end
    end

    assign rise = alarm_match & ~match_d;

    // State, timers and registered outputs; reset silences the buzzer at once.
    always_ff @(posedge clk_10Hz or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            phase_q  <= '0;
            snz_q    <= '0;
            buzzer_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            phase_q  <= phase_n;
            snz_q    <= snz_n;
            buzzer_q <= buzzer_n;
            led_q    <= led_n;
        end
    end

    // Next-state, timer and output decode; alarm_en low overrides everything.
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        phase_n  = phase_q;
        snz_n    = snz_q;
        buzzer_n = 1'b0;
        led_n    = 1'b0;

        // Outputs are registered from the state and phase before this edge.
        unique case (state_q)
            ST_RING: begin
                buzzer_n = beep_on(phase_q);
                led_n    = blink_on(phase_q);
            end
            ST_SNOOZE: begin
                buzzer_n = 1'b0;
                led_n    = 1'b1;
            end
            default: begin
                buzzer_n = chime_in;
                led_n    = 1'b0;
            end
        endcase

        if (!alarm_en) begin
            state_n = ST_IDLE;
            tick_n  = '0;
            phase_n = '0;
            snz_n   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_n = ST_RING;
                        tick_n  = '0;
                        phase_n = '0;
                        snz_n   = '0;
                    end
                end

                ST_RING: begin
                    if (stop_press) begin
                        state_n = ST_DISMISSED;
                        tick_n  = '0;
                        phase_n = '0;
                    end else if (snooze_press) begin
                        tick_n  = '0;
                        phase_n = '0;
                        if (snz_q < SNZ_MAX) begin
                            state_n = ST_SNOOZE;
                            snz_n   = snz_q + 2'd1;
                        end else begin
                            state_n = ST_DISMISSED;
                        end
                    end else if (tick_q == RING_LAST) begin
                        state_n = ST_DISMISSED;
                        tick_n  = '0;
                        phase_n = '0;
                    end else begin
                        tick_n  = tick_q + CNT_W'(1);
                        phase_n = (phase_q == PH_LAST) ? '0 : phase_q + 4'd1;
                    end
                end

                ST_SNOOZE: begin
                    // Snooze presses are deliberately ignored while snoozing.
                    if (stop_press) begin
                        state_n = ST_DISMISSED;
                        tick_n  = '0;
                        phase_n = '0;
                    end else if (tick_q == SNOOZE_LAST) begin
                        state_n = ST_RING;
                        tick_n  = '0;
                        phase_n = '0;
                    end else begin
                        tick_n  = tick_q + CNT_W'(1);
                    end
                end

                ST_DISMISSED: begin
                    if (!alarm_match) begin
                        state_n = ST_IDLE;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign buzzer     = buzzer_q;
    assign alarm_led  = led_q;
    assign ring_state = state_q;
    assign snooze_cnt = snz_q;

endmodule
